pl_stage_reg: RTL

Generic, parametrised pipeline stage register for the RISC-V pipelined CPU, intended to replace the per-boundary fixed registers (F/D, D/E, E/M, M/W). It carries a control bundle and a data bundle between two stages under a valid/ready handshake. It supports stall (back-pressure), synchronous flush with bubble injection, an optional 2-entry skid buffer that breaks the combinational ready path, and a saturating stall-cycle counter for performance analysis.

---
 rtl/pl_pkg.sv | 68 ++++++
 rtl/pl_skid_buf.sv | 68 ++++++
 rtl/pl_stage_reg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline stage registers: NOP control encoding,
// per-boundary control field layout and bundle typedefs.
// No logic here; latency and backpressure are defined by pl_stage_reg.
package pl_pkg;

    localparam int PL_CTRL_W = 16;
    localparam int PL_DATA_W = 160;

    // All-zero control never writes the register file or memory and never
    // redirects the PC, so it is a safe bubble at every boundary.
    localparam logic [PL_CTRL_W-1:0] PL_CTRL_BUBBLE = '0;

    // Control field offsets (LSB position) within the D/E bundle.
    localparam int DE_ALU_SRC_OFS    = 6;
    localparam int DE_ALU_CTRL_OFS   = 7;
    localparam int DE_ALU_CTRL_W     = 3;
    localparam int DE_BRANCH_OFS     = 10;
    localparam int DE_JUMP_OFS       = 11;
    localparam int DE_MEM_WRITE_OFS  = 12;
    localparam int DE_RESULT_SRC_OFS = 13;
    localparam int DE_RESULT_SRC_W   = 2;
    localparam int DE_REG_WRITE_OFS  = 15;

    // E/M and M/W keep reg_write/result_src in the same top bits so the
    // forwarding and hazard logic can read them without per-stage decode.
    localparam int EM_MEM_WRITE_OFS  = 12;
    localparam int EM_RESULT_SRC_OFS = 13;
    localparam int EM_REG_WRITE_OFS  = 15;
    localparam int MW_RESULT_SRC_OFS = 13;
    localparam int MW_REG_WRITE_OFS  = 15;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
        logic [5:0] rsvd;
    } de_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic [11:0] rsvd;
    } em_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [12:0] rsvd;
    } mw_ctrl_t;

    // D/E data bundle; PCPlus4 is recomputed from pc downstream.
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [16:0] rsvd;
    } de_data_t;

endpackage

// File: rtl/pl_skid_buf.sv
// Skid entry for pl_stage_reg: holds one bundle that arrived while the main
// register was stalled, and a registered ready (1 whenever the entry is empty).
// Latency: entry visible the edge after load. Backpressure: rdy_q drops while full.
// Ports: clk, rst_n, clr | load_vld/load_ctrl/load_data (push) | pop |
//        skid_vld/skid_ctrl/skid_data (entry contents) | in_rdy (registered).
// Only compiled when PL_STAGE_SKID_EN is defined.
`ifdef PL_STAGE_SKID_EN
module pl_skid_buf #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_vld,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    output logic              skid_vld,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data,
    output logic              in_rdy
);

    logic              skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              rdy_q, rdy_d;

    // load and pop are mutually exclusive: load only happens while the main
    // register is stalled, pop only while it can take a bundle.
    always_comb begin
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (clr) begin
            skid_vld_d = 1'b0;
        end else if (load_vld) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = load_ctrl;
            skid_data_d = load_data;
        end else if (pop) begin
            skid_vld_d = 1'b0;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            rdy_q       <= 1'b1;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
        end
    end

    assign skid_vld  = skid_vld_q;
    assign skid_ctrl = skid_ctrl_q;
    assign skid_data = skid_data_q;
    assign in_rdy    = rdy_q;

endmodule
`endif

// File: rtl/pl_stage_reg.sv
// Generic valid/ready pipeline stage register with flush/bubble and stall counter.
// Latency: 1 cycle input fire to output. Backpressure: in_ready from out_ready
// (combinational), or registered via a 2-entry skid when PL_STAGE_SKID_EN is defined.
// Ports: clk, rst_n (async, active-low), clr (sync flush) |
//        in_valid/in_ready/in_ctrl/in_data | out_valid/out_ready/out_ctrl/out_data |
//        stall_cnt (saturating count of cycles with out_valid & ~out_ready).
module pl_stage_reg
    import pl_pkg::*;
#(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 160,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PL_CTRL_BUBBLE),
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]      out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    assign out_fire = out_valid_q & out_ready;
    // An input presented during clr is killed, so it never counts as a fire.
    assign in_fire  = in_valid & in_ready & ~clr;

`ifdef PL_STAGE_SKID_EN
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_rdy;
    logic              main_open;

    // Main register can take a bundle when empty or delivering this cycle.
    assign main_open = ~out_valid_q | out_ready;

    pl_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load_vld  (in_fire & ~main_open),
        .load_ctrl (in_ctrl),
        .load_data (in_data),
        .pop       (skid_vld & main_open),
        .skid_vld  (skid_vld),
        .skid_ctrl (skid_ctrl),
        .skid_data (skid_data),
        .in_rdy    (skid_rdy)
    );

    // clr forces acceptance so upstream sees its bundle as consumed (killed).
    assign in_ready = skid_rdy | clr;

    // The skid is only ever full while main is full, and in_ready is low
    // while the skid is full, so a skid move and an input fire never collide.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = CTRL_BUBBLE;
            out_data_d  = '0;
        end else if (main_open) begin
            if (skid_vld) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = skid_ctrl;
                out_data_d  = skid_data;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
                out_ctrl_d  = CTRL_BUBBLE;
            end
        end
    end
`else
    assign in_ready = ~out_valid_q | out_ready | clr;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = CTRL_BUBBLE;
            out_data_d  = '0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
        end else if (out_fire) begin
            // Bubble: control becomes a NOP, data is left as-is.
            out_valid_d = 1'b0;
            out_ctrl_d  = CTRL_BUBBLE;
        end
    end
`endif

    // Counts on every stalled cycle, including during clr.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_BUBBLE;
            out_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
